// File: rtl/result_bus_arbiter_pkg.sv
// Shared types for the result bus arbiter: occupancy states, byte-wide index types,
// and the pointer wrap helper.
package result_bus_arbiter_pkg;

  typedef logic [7:0] w8;
  typedef logic [7:0] r8;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_TWO   = 2'd2
  } ArbOcc_t;

  // Next round-robin start after index w, wrapping by explicit compare against the last index.
  function automatic w8 ptr_after(input w8 w, input w8 last);
    return (w == last) ? 8'd0 : w + 8'd1;
  endfunction

endpackage

// File: rtl/result_bus_arbiter_rr_pick.sv
// Rotating-priority encoder: the first set request at or after ptr, wrapping modulo N.
module rr_pick
  import result_bus_arbiter_pkg::*;
#(
  parameter int N = 7
) (
  input  logic [N-1:0] req,
  input  w8            ptr,
  output w8            idx,
  output logic         none
);

  logic [2*N-1:0] dbl_s;
  w8              pos_s;
  logic           found_s;

  // Mask the lower copy below ptr so the upper copy supplies the wrapped-around requesters.
  always_comb begin
    dbl_s = {req, req};
    for (int j = 0; j < N; j++) begin
      dbl_s[j] = req[j] & (j >= int'(ptr));
    end
    found_s = 1'b0;
    pos_s   = 8'd0;
    for (int j = 0; j < 2*N; j++) begin
      pos_s   = (!found_s && dbl_s[j]) ? 8'(j) : pos_s;
      found_s = found_s | dbl_s[j];
    end
    none = ~found_s;
    idx  = (pos_s >= 8'(N)) ? (pos_s - 8'(N)) : pos_s;
  end

endmodule

// File: rtl/result_bus_arbiter.sv
// Completion bus arbiter: sticky round-robin with a burst cap feeding a 2-entry skid buffer,
// so a downstream reject never reaches the functional units combinationally.
module result_bus_arbiter
  import result_bus_arbiter_pkg::*;
#(
  parameter int NUM_REQ   = 7,
  parameter int DATA_W    = 49,
  parameter int MAX_BURST = 4
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      flash,
  input  logic [NUM_REQ-1:0]        req_en,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_reject,
  output logic                      out_en,
  output logic [DATA_W-1:0]         out_data,
  input  logic                      out_reject,
  output logic [7:0]                grant_idx,
  output logic                      grant_vld
);

  localparam int BW = $clog2(MAX_BURST + 1);

  ArbOcc_t           state_r;
  r8                 ptr_r;
  logic [BW-1:0]     burst_cnt_r;
  logic [DATA_W-1:0] main_r;
  logic [DATA_W-1:0] skid_r;

  w8                 win_idx_s;
  logic              none_s;
  logic              can_accept_s;
  logic              accept_s;
  logic              pop_s;
  logic [DATA_W-1:0] sel_data_s;

  rr_pick #(.N(NUM_REQ)) u_pick (
    .req  (req_en),
    .ptr  (ptr_r),
    .idx  (win_idx_s),
    .none (none_s)
  );

  // Accept decision depends only on registered occupancy, never on out_reject.
  always_comb begin
    can_accept_s = (state_r != OCC_TWO) & ~flash & ~reset;
    accept_s     = can_accept_s & ~none_s;
    out_en       = (state_r != OCC_EMPTY) & ~flash;
    out_data     = main_r;
    pop_s        = out_en & ~out_reject;
    grant_vld    = accept_s;
    grant_idx    = accept_s ? win_idx_s : 8'd0;
    req_reject   = {NUM_REQ{1'b1}};
    sel_data_s   = {DATA_W{1'b0}};
    for (int i = 0; i < NUM_REQ; i++) begin
      req_reject[i] = ~(accept_s & (win_idx_s == 8'(i)));
      sel_data_s    = (win_idx_s == 8'(i)) ? req_data[i*DATA_W +: DATA_W] : sel_data_s;
    end
  end

  // Occupancy FSM, main/skid data registers and round-robin pointer with burst count.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r     <= OCC_EMPTY;
      ptr_r       <= 8'd0;
      burst_cnt_r <= {BW{1'b0}};
      main_r      <= {DATA_W{1'b0}};
      skid_r      <= {DATA_W{1'b0}};
    end else if (flash) begin
      state_r     <= OCC_EMPTY;
      ptr_r       <= 8'd0;
      burst_cnt_r <= {BW{1'b0}};
    end else begin
      case (state_r)
        OCC_EMPTY: begin
          if (accept_s) begin
            main_r  <= sel_data_s;
            state_r <= OCC_ONE;
          end
        end
        OCC_ONE: begin
          if (accept_s && pop_s) begin
            main_r <= sel_data_s;
          end else if (accept_s) begin
            skid_r  <= sel_data_s;
            state_r <= OCC_TWO;
          end else if (pop_s) begin
            state_r <= OCC_EMPTY;
          end
        end
        OCC_TWO: begin
          if (pop_s) begin
            main_r  <= skid_r;
            state_r <= OCC_ONE;
          end
        end
        default: state_r <= OCC_EMPTY;
      endcase
      if (accept_s) begin
        if ((win_idx_s == ptr_r) && ((int'(burst_cnt_r) + 1) < MAX_BURST)) begin
          burst_cnt_r <= burst_cnt_r + BW'(1);
        end else begin
          ptr_r       <= ptr_after(win_idx_s, 8'(NUM_REQ - 1));
          burst_cnt_r <= {BW{1'b0}};
        end
      end
    end
  end

endmodule

// File: tb/tb_result_bus_arbiter.sv
// Directed bench for result_bus_arbiter: arbitration order, skid buffering, flash and reset.
module tb_result_bus_arbiter;
  localparam int NR = 7;
  localparam int DW = 49;
  localparam logic [NR-1:0] ALL = 7'h7F;

  logic               clock = 1'b0;
  logic               reset, flash, out_reject;
  logic [NR-1:0]      req_en, req_reject;
  logic [NR*DW-1:0]   req_data;
  logic               out_en, grant_vld;
  logic [DW-1:0]      out_data;
  logic [7:0]         grant_idx;
  int n_cmp = 0;
  int n_bad = 0;

  result_bus_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .MAX_BURST(4)) dut (
    .clock(clock), .reset(reset), .flash(flash), .req_en(req_en), .req_data(req_data),
    .req_reject(req_reject), .out_en(out_en), .out_data(out_data), .out_reject(out_reject),
    .grant_idx(grant_idx), .grant_vld(grant_vld)
  );

  always #5 clock = ~clock;

  function automatic logic [DW-1:0] pay(input int i, input int c);
    logic [DW-1:0] v;
    v = {8'(i), 41'(c)};
    return v;
  endfunction

  task automatic drive(input logic [NR-1:0] en, input int tag);
    req_en = en;
    for (int i = 0; i < NR; i++) req_data[i*DW +: DW] = pay(i, tag);
  endtask

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; flash = 1'b0; out_reject = 1'b0;
    drive(ALL, 0);
    repeat (2) @(posedge clock);
    #2;
    n_cmp++; if (out_en !== 1'b0) begin n_bad++; $display("FAIL reset_out_en: got %b want 0", out_en); end
    n_cmp++; if (grant_vld !== 1'b0) begin n_bad++; $display("FAIL reset_grant_vld: got %b want 0", grant_vld); end
    n_cmp++; if (grant_idx !== 8'd0) begin n_bad++; $display("FAIL reset_grant_idx: got %0d want 0", grant_idx); end
    n_cmp++; if (req_reject !== ALL) begin n_bad++; $display("FAIL reset_req_reject: got %b want %b", req_reject, ALL); end
    req_en = '0;
    reset = 1'b0;
    next_cycle();
  endtask

  // Requester 3 alone for n cycles, starting from an empty buffer.
  task automatic run_single(input int n);
    for (int k = 0; k < n; k++) begin
      drive(7'b0001000, k);
      #1;
      n_cmp++;
      if ({grant_vld, grant_idx} !== {1'b1, 8'd3}) begin
        n_bad++; $display("FAIL single_grant k=%0d: got %b/%0d want 1/3", k, grant_vld, grant_idx);
      end
      n_cmp++;
      if (req_reject !== 7'b1110111) begin
        n_bad++; $display("FAIL single_reject k=%0d: got %b want 1110111", k, req_reject);
      end
      n_cmp++;
      if (k == 0) begin
        if (out_en !== 1'b0) begin n_bad++; $display("FAIL single_first_out k=0: got out_en %b want 0", out_en); end
      end else if ({out_en, out_data} !== {1'b1, pay(3, k-1)}) begin
        n_bad++; $display("FAIL single_out k=%0d: got %b/%h want 1/%h", k, out_en, out_data, pay(3, k-1));
      end
      next_cycle();
    end
    drive('0, 0);
    #1;
    n_cmp++;
    if ({out_en, out_data} !== {1'b1, pay(3, n-1)}) begin
      n_bad++; $display("FAIL single_last_out: got %b/%h want 1/%h", out_en, out_data, pay(3, n-1));
    end
    next_cycle();
    #1;
    n_cmp++; if (out_en !== 1'b0) begin n_bad++; $display("FAIL single_drain: got out_en %b want 0", out_en); end
    next_cycle();
  endtask

  task automatic do_flash();
    drive(ALL, 99);
    flash = 1'b1;
    #1;
    n_cmp++; if (req_reject !== ALL) begin n_bad++; $display("FAIL flash_reject: got %b want %b", req_reject, ALL); end
    n_cmp++; if (grant_vld !== 1'b0) begin n_bad++; $display("FAIL flash_grant_vld: got %b want 0", grant_vld); end
    n_cmp++; if (out_en !== 1'b0) begin n_bad++; $display("FAIL flash_out_en: got %b want 0", out_en); end
    next_cycle();
    flash = 1'b0;
    drive('0, 0);
    #1;
    n_cmp++; if (out_en !== 1'b0) begin n_bad++; $display("FAIL post_flash_out_en: got %b want 0", out_en); end
    next_cycle();
  endtask

  task automatic test_all_rr();
    int g, prev_g;
    prev_g = 0;
    for (int k = 0; k < 29; k++) begin
      g = (k < 28) ? ((k / 4) % 7) : 0;
      drive(ALL, k);
      #1;
      n_cmp++;
      if ({grant_vld, grant_idx} !== {1'b1, 8'(g)}) begin
        n_bad++; $display("FAIL rr_grant k=%0d: got %b/%0d want 1/%0d", k, grant_vld, grant_idx, g);
      end
      n_cmp++;
      if (req_reject !== 7'(~(7'b1 << g))) begin
        n_bad++; $display("FAIL rr_reject k=%0d: got %b want %b", k, req_reject, 7'(~(7'b1 << g)));
      end
      if (k > 0) begin
        n_cmp++;
        if ({out_en, out_data} !== {1'b1, pay(prev_g, k-1)}) begin
          n_bad++; $display("FAIL rr_out k=%0d: got %b/%h want 1/%h", k, out_en, out_data, pay(prev_g, k-1));
        end
      end
      prev_g = g;
      next_cycle();
    end
    do_flash();
  endtask

  task automatic test_skid();
    int g_exp [10] = '{1, 5, 1, 5, -1, -1, -1, -1, 1, 5};
    int o_idx [10] = '{-1, 1, 5, 1, 1, 1, 1, 1, 5, 1};
    int o_tag [10] = '{0, 0, 1, 2, 2, 2, 2, 2, 3, 8};
    for (int k = 0; k < 10; k++) begin
      out_reject = (k >= 3 && k <= 6);
      drive(7'b0100010, k);
      #1;
      n_cmp++;
      if (g_exp[k] < 0) begin
        if ({grant_vld, req_reject} !== {1'b0, ALL}) begin
          n_bad++; $display("FAIL skid_full k=%0d: got %b/%b want 0/%b", k, grant_vld, req_reject, ALL);
        end
      end else if ({grant_vld, grant_idx} !== {1'b1, 8'(g_exp[k])}) begin
        n_bad++; $display("FAIL skid_grant k=%0d: got %b/%0d want 1/%0d", k, grant_vld, grant_idx, g_exp[k]);
      end
      n_cmp++;
      if (o_idx[k] < 0) begin
        if (out_en !== 1'b0) begin n_bad++; $display("FAIL skid_out_en k=%0d: got %b want 0", k, out_en); end
      end else if ({out_en, out_data} !== {1'b1, pay(o_idx[k], o_tag[k])}) begin
        n_bad++; $display("FAIL skid_out k=%0d: got %b/%h want 1/%h", k, out_en, out_data, pay(o_idx[k], o_tag[k]));
      end
      next_cycle();
    end
    out_reject = 1'b0;
    do_flash();
  endtask

  task automatic test_flash_two();
    int g_exp [2] = '{2, 5};
    out_reject = 1'b1;
    for (int k = 0; k < 2; k++) begin
      drive(7'b0100100, k);
      #1;
      n_cmp++;
      if ({grant_vld, grant_idx} !== {1'b1, 8'(g_exp[k])}) begin
        n_bad++; $display("FAIL ft_grant k=%0d: got %b/%0d want 1/%0d", k, grant_vld, grant_idx, g_exp[k]);
      end
      next_cycle();
    end
    drive(7'b0100100, 2);
    #1;
    n_cmp++;
    if ({grant_vld, req_reject, out_en, out_data} !== {1'b0, ALL, 1'b1, pay(2, 0)}) begin
      n_bad++; $display("FAIL ft_two: got %b/%b/%b/%h want 0/%b/1/%h", grant_vld, req_reject, out_en, out_data, ALL, pay(2, 0));
    end
    next_cycle();
    do_flash();
    out_reject = 1'b0;
    drive(7'b0100100, 10);
    #1;
    n_cmp++;
    if ({out_en, grant_vld, grant_idx} !== {1'b0, 1'b1, 8'd2}) begin
      n_bad++; $display("FAIL ft_restart: got %b/%b/%0d want 0/1/2", out_en, grant_vld, grant_idx);
    end
    next_cycle();
    drive('0, 0);
    #1;
    n_cmp++;
    if ({out_en, out_data} !== {1'b1, pay(2, 10)}) begin
      n_bad++; $display("FAIL ft_restart_out: got %b/%h want 1/%h", out_en, out_data, pay(2, 10));
    end
    next_cycle();
    do_flash();
  endtask

  task automatic test_burst_drop();
    logic [NR-1:0] en_v [6] = '{7'b0000010, 7'b1000100, 7'b1000100, 7'b1000000, 7'b1000100, 7'b0000000};
    int g_exp [6] = '{1, 2, 2, 6, 2, -1};
    for (int k = 0; k < 6; k++) begin
      drive(en_v[k], k);
      #1;
      if (g_exp[k] >= 0) begin
        n_cmp++;
        if ({grant_vld, grant_idx} !== {1'b1, 8'(g_exp[k])}) begin
          n_bad++; $display("FAIL burst_grant k=%0d: got %b/%0d want 1/%0d", k, grant_vld, grant_idx, g_exp[k]);
        end
      end
      if (k > 0) begin
        n_cmp++;
        if ({out_en, out_data} !== {1'b1, pay(g_exp[k-1], k-1)}) begin
          n_bad++; $display("FAIL burst_out k=%0d: got %b/%h want 1/%h", k, out_en, out_data, pay(g_exp[k-1], k-1));
        end
      end
      next_cycle();
    end
    do_flash();
  endtask

  task automatic test_async_reset();
    drive(7'b0001000, 0);
    next_cycle();
    drive(7'b0001000, 1);
    #1;
    n_cmp++;
    if ({out_en, out_data} !== {1'b1, pay(3, 0)}) begin
      n_bad++; $display("FAIL ar_before: got %b/%h want 1/%h", out_en, out_data, pay(3, 0));
    end
    #1;
    reset = 1'b1;
    #1;
    n_cmp++;
    if ({out_en, grant_vld, req_reject} !== {1'b0, 1'b0, ALL}) begin
      n_bad++; $display("FAIL ar_during: got %b/%b/%b want 0/0/%b", out_en, grant_vld, req_reject, ALL);
    end
    next_cycle();
    drive('0, 0);
    reset = 1'b0;
    run_single(6);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    run_single(8);
    do_flash();
    test_all_rr();
    test_skid();
    test_flash_two();
    test_burst_drop();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
